// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq: iterative unsigned multiply/divide sequencer for the EX stage.
// Radix-2 shift-add multiply (MUL/MULH) and restoring divide (DIV/REM), one
// iteration per clock, WIDTH iterations per operation. Holds the pipeline with
// stall while running and returns a registered result with a 1-cycle done.
// Optional feature macro: MULDIV_EARLY_OUT_EN (zero-operand multiply and a<b
// divide finish on the short path in one cycle).
module ex_muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULH = 2'b01,
    OP_DIV  = 2'b10,
    OP_REM  = 2'b11
  } op_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  op_t              op_q;
  logic [WIDTH-1:0] b_q;
  // hi_q: upper product half for multiply (top bit always 0 there), partial
  // remainder for divide. lo_q: lower product half / dividend-quotient shifter.
  logic [WIDTH:0]   hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             accept;
  logic             short_path;
  logic [WIDTH-1:0] short_res;
  logic             last_iter;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_trial;
  logic [WIDTH:0]   hi_nx;
  logic [WIDTH-1:0] lo_nx;
  logic [WIDTH-1:0] fin_res;

  assign accept    = (state_q == S_IDLE) && start && !flush;
  assign last_iter = (count_q == LAST_CNT);

  // Decide whether the incoming request completes without iterating, and its result.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    short_path = 1'b0;
    short_res  = '0;
    if (op[1] && (b == '0)) begin
      // Divide by zero: quotient all ones, remainder is the dividend.
      short_path = 1'b1;
      short_res  = op[0] ? a : '1;
    end
`ifdef MULDIV_EARLY_OUT_EN
    else if (!op[1] && ((a == '0) || (b == '0))) begin
      short_path = 1'b1;
      short_res  = '0;
    end else if (op[1] && (a < b)) begin
      short_path = 1'b1;
      short_res  = op[0] ? a : '0;
    end
`endif
  end

  // One radix-2 iteration of the selected algorithm, plus the result it would yield.
  always_comb begin
    mul_sum   = hi_q + {1'b0, b_q};
    div_shift = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
    div_trial = {1'b0, div_shift} - {2'b00, b_q};
    hi_nx     = hi_q;
    lo_nx     = lo_q;
    if (op_q == OP_DIV || op_q == OP_REM) begin
      if (!div_trial[WIDTH+1]) begin
        hi_nx = div_trial[WIDTH:0];
        lo_nx = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_nx = div_shift;
        lo_nx = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (lo_q[0]) begin
        hi_nx = {1'b0, mul_sum[WIDTH:1]};
        lo_nx = {mul_sum[0], lo_q[WIDTH-1:1]};
      end else begin
        hi_nx = {1'b0, hi_q[WIDTH:1]};
        lo_nx = {hi_q[0], lo_q[WIDTH-1:1]};
      end
    end
    case (op_q)
      OP_MUL:  fin_res = lo_nx;
      OP_MULH: fin_res = hi_nx[WIDTH-1:0];
      OP_DIV:  fin_res = lo_nx;
      OP_REM:  fin_res = hi_nx[WIDTH-1:0];
      default: fin_res = lo_nx;
    endcase
  end

  // Next-state and stall decode.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          stall   = !short_path;
          state_d = short_path ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        stall = !flush;
        if (flush) begin
          state_d = S_IDLE;
        end else if (last_iter) begin
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
    end
  end

  // Operand capture, iteration datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: datapath registers are reset too, since outputs and operand
      // registers must read zero immediately after reset.
      count_q  <= '0;
      op_q     <= OP_MUL;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      div_zero <= 1'b0;
    end else begin
      busy <= (state_d != S_IDLE);
      done <= (state_d == S_FIN);
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q    <= op_t'(op);
            b_q     <= b;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= a;
            if (short_path) begin
              result   <= short_res;
              div_zero <= op[1] && (b == '0);
            end
          end
        end
        S_RUN: begin
          if (flush) begin
            count_q <= '0;
          end else begin
            hi_q <= hi_nx;
            lo_q <= lo_nx;
            if (last_iter) begin
              count_q  <= '0;
              result   <= fin_res;
              div_zero <= 1'b0;
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
        end
        default: count_q <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// tb_ex_muldiv_seq: directed self-checking bench for ex_muldiv_seq.
// Expected values are hand-computed; latencies depend on MULDIV_EARLY_OUT_EN.
module tb_ex_muldiv_seq;

  localparam int W        = 32;
  localparam int LAT_FULL = W + 1;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          stall, busy, done, div_zero;
  logic [W-1:0]  result;

  int checks   = 0;
  int failures = 0;

  ex_muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .stall    (stall),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Issue one op and follow it to done; inputs change #1 after posedge,
  // outputs are sampled on the negedge.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] xa,
                        input logic [W-1:0] xb, input logic [W-1:0] exp_res,
                        input logic exp_dz, input int exp_lat);
    int lat;
    int stall_cnt;
    bit seen;
    @(posedge clk); #1;
    start = 1'b1; op = o; a = xa; b = xb;
    @(negedge clk);
    check({tag, "_stall_accept"}, {31'b0, stall}, {31'b0, exp_lat != 1});
    @(posedge clk); #1;
    start = 1'b0; a = '0; b = '0;
    lat = 1; stall_cnt = 0; seen = 1'b0;
    while (!seen && lat <= 100) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        if (stall) stall_cnt++;
        lat++;
      end
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_div_zero"}, {31'b0, div_zero}, {31'b0, exp_dz});
    check({tag, "_stall_done"}, {31'b0, stall}, 32'd0);
    check({tag, "_stall_cycles"}, stall_cnt, exp_lat - 1);
    @(negedge clk);
    check({tag, "_done_drop"}, {31'b0, done}, 32'd0);
    check({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int done_cnt;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_div_zero", {31'b0, div_zero}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Multiply and divide vectors.
    run_op("mul_7x6",   2'b00, 32'd7, 32'd6, 32'd42, 1'b0, LAT_FULL);
    run_op("mulh_ff",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, LAT_FULL);
    run_op("mul_ff",    2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, LAT_FULL);
    run_op("mul_shift", 2'b00, 32'h1234_5678, 32'h10, 32'h2345_6780, 1'b0, LAT_FULL);
    run_op("mulh_shift",2'b01, 32'h1234_5678, 32'h10, 32'h0000_0001, 1'b0, LAT_FULL);
    run_op("div_100_7", 2'b10, 32'd100, 32'd7, 32'd14, 1'b0, LAT_FULL);
    run_op("rem_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 1'b0, LAT_FULL);
    run_op("div_max_1", 2'b10, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, LAT_FULL);
    run_op("rem_max_1", 2'b11, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, LAT_FULL);
    run_op("div_5_0",   2'b10, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1);
    run_op("rem_5_0",   2'b11, 32'd5, 32'd0, 32'd5, 1'b1, 1);
    run_op("div_3_10",  2'b10, 32'd3, 32'd10, 32'd0, 1'b0, EO ? 1 : LAT_FULL);
    run_op("rem_3_10",  2'b11, 32'd3, 32'd10, 32'd3, 1'b0, EO ? 1 : LAT_FULL);
    run_op("mul_0x5",   2'b00, 32'd0, 32'd5, 32'd0, 1'b0, EO ? 1 : LAT_FULL);
    run_op("mul_3x5",   2'b00, 32'd3, 32'd5, 32'd15, 1'b0, LAT_FULL);

    // Flush mid-RUN: start in cycle N, flush in N+10.
    @(posedge clk); #1;
    start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flush_run_stall", {31'b0, stall}, 32'd0);
    check("flush_run_busy_before", {31'b0, busy}, 32'd1);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flush_run_busy_after", {31'b0, busy}, 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("flush_run_no_done", done_cnt, 32'd0);
    check("flush_run_result_hold", result, 32'd15);

    // Flush landing in FIN: done already high drops the next cycle.
    @(posedge clk); #1;
    start = 1'b1; op = 2'b10; a = 32'd9; b = 32'd0;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b1;
    @(negedge clk);
    check("flush_fin_done", {31'b0, done}, 32'd1);
    check("flush_fin_result", result, 32'hFFFF_FFFF);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flush_fin_done_drop", {31'b0, done}, 32'd0);
    check("flush_fin_busy", {31'b0, busy}, 32'd0);

    // start during FIN is not accepted.
    @(posedge clk); #1;
    start = 1'b1; op = 2'b11; a = 32'd5; b = 32'd0;
    @(posedge clk); #1;
    op = 2'b00; a = 32'd7; b = 32'd6;
    @(negedge clk);
    check("fin_start_done", {31'b0, done}, 32'd1);
    check("fin_start_result", result, 32'd5);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("fin_start_ignored", {31'b0, busy}, 32'd0);

    // start together with flush in IDLE: nothing accepted.
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; op = 2'b00; a = 32'd7; b = 32'd6;
    @(negedge clk);
    check("idle_flush_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("idle_flush_busy", {31'b0, busy}, 32'd0);

    // Asynchronous reset in the middle of RUN.
    run_op("mul_pre_rst", 2'b00, 32'd9, 32'd9, 32'd81, 1'b0, LAT_FULL);
    @(posedge clk); #1;
    start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_done", {31'b0, done}, 32'd0);
    check("rst_mid_result", result, 32'd0);
    check("rst_mid_div_zero", {31'b0, div_zero}, 32'd0);
    check("rst_mid_stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Sequencer works normally after reset.
    run_op("mul_post_rst", 2'b00, 32'd0, 32'd9, 32'd0, 1'b0, EO ? 1 : LAT_FULL);
    run_op("div_post_rst", 2'b10, 32'd81, 32'd9, 32'd9, 1'b0, LAT_FULL);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
